// File: rtl/mem_responder.sv
// Word-addressed RAM responder with programmable wait states and MemReady pulse.
// Optional MMIO (LED register, cycle counter) enabled by defining MEM_MMIO_EN.
module mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemError,
  output logic        Busy,
  output logic [7:0]  leds
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH_WORDS];

`ifdef MEM_MMIO_EN
  logic [31:0] cyc;
`endif

  logic [31:0] sel_addr;
  logic [31:0] word;
  logic [AW-1:0] idx;
  logic        in_ram;
  logic        is_led;
  logic        is_cyc;
  logic        hit_err;
  logic [31:0] rd_val;
  logic        req;
  logic        enter_resp;
  logic        wr_next;

  // Address decode follows the live bus while idle, the latched copy otherwise.
  always_comb begin
    sel_addr = (state == IDLE) ? Address : addr_q;
    word     = (sel_addr - BASE_ADDR) >> 2;
    idx      = word[AW-1:0];
    in_ram   = (sel_addr >= BASE_ADDR) && (word < 32'(DEPTH_WORDS));
    is_led   = 1'b0;
    is_cyc   = 1'b0;
`ifdef MEM_MMIO_EN
    is_led   = (sel_addr == 32'h4000_0000);
    is_cyc   = (sel_addr == 32'h4000_0004);
`endif
    hit_err  = !(in_ram || is_led || is_cyc);
    rd_val   = '0;
    if (is_led) begin
      rd_val = {24'b0, leds};
`ifdef MEM_MMIO_EN
    end else if (is_cyc) begin
      rd_val = cyc;
`endif
    end else if (in_ram) begin
      rd_val = mem[idx];
    end
  end

  always_comb begin
    req        = MemRead || MemWrite;
    wr_next    = (state == IDLE) ? MemWrite : op_wr;
    enter_resp = 1'b0;
    unique case (1'b1)
      (state == IDLE): enter_resp = req && (LATENCY == 0);
      (state == WAIT): enter_resp = (cnt == LAST);
      default:         enter_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ReadData <= '0;
      MemReady <= 1'b0;
      MemError <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      MemError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= MemWrite;
            addr_q  <= Address;
            wdata_q <= WriteData;
            Busy    <= 1'b1;
            cnt     <= '0;
            state   <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == LAST) state <= RESP;
          else cnt <= cnt + 4'd1;
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        MemReady <= 1'b1;
        MemError <= hit_err;
        if (!wr_next) ReadData <= rd_val;
      end
    end
  end

  // Stores commit on the edge leaving RESP; a reset on that edge drops them.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && op_wr && in_ram && !is_led && !is_cyc)
      mem[idx] <= wdata_q;
  end

`ifdef MEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      leds <= '0;
      cyc  <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (state == RESP && op_wr && is_led) leds <= wdata_q[7:0];
    end
  end
`else
  assign leds = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: instance 0 has LATENCY=2, instance 1 LATENCY=0.
// Expected responses are queued at request time and popped on MemReady.
module tb_mem_responder;

  typedef struct {
    int          d;
    logic [31:0] data;
    logic        err;
    bit          chk;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_i [2];
  logic        wr_i [2];
  logic [31:0] addr_i [2];
  logic [31:0] wd_i [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err [2];
  logic        busy [2];
  logic [7:0]  leds_o [2];

  exp_t        sb [$];
  logic [31:0] last_rd [2];
  int          tb_cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .reset(reset), .MemRead(rd_i[0]), .MemWrite(wr_i[0]),
    .Address(addr_i[0]), .WriteData(wd_i[0]), .ReadData(rdata[0]),
    .MemReady(ready[0]), .MemError(err[0]), .Busy(busy[0]), .leds(leds_o[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .MemRead(rd_i[1]), .MemWrite(wr_i[1]),
    .Address(addr_i[1]), .WriteData(wd_i[1]), .ReadData(rdata[1]),
    .MemReady(ready[1]), .MemError(err[1]), .Busy(busy[1]), .leds(leds_o[1])
  );

  task automatic txn(input int d, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic exp_err, input bit chk,
                     input logic [31:0] exp_rd, input string nm,
                     output logic [31:0] got, output int acc);
    exp_t e;
    int   k;
    bit   seen;
    int   lat;
    lat = (d == 0) ? 3 : 1;
    @(negedge clk);
    rd_i[d] = rd;
    wr_i[d] = wr;
    addr_i[d] = a;
    wd_i[d] = wd;
    acc = tb_cyc + 1;
    e.d = d;
    e.err = exp_err;
    e.nm = nm;
    if (wr) begin
      e.data = last_rd[d];
      e.chk = 1'b1;
    end else begin
      e.data = exp_err ? 32'h0 : exp_rd;
      e.chk = chk || exp_err;
    end
    sb.push_back(e);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (ready[d] === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    got = rdata[d];
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no MemReady after %0d cycles", e.nm, k);
    end else begin
      checks++;
      if (k != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", e.nm, k, lat);
      end
      if (e.chk) begin
        checks++;
        if (rdata[d] !== e.data) begin
          errors++;
          $display("FAIL %s data: got %h want %h", e.nm, rdata[d], e.data);
        end
      end
      checks++;
      if (err[d] !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b want %b", e.nm, err[d], e.err);
      end
      checks++;
      if (busy[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_resp: got %b want 1", e.nm, busy[d]);
      end
    end
    if (!wr) last_rd[d] = e.chk ? e.data : got;
    rd_i[d] = 1'b0;
    wr_i[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got ready=%b busy=%b want 0 0", e.nm, ready[d], busy[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rd_i[d] = 1'b0;
      wr_i[d] = 1'b0;
      addr_i[d] = '0;
      wd_i[d] = '0;
      last_rd[d] = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata%0d: got %h want 0", d, rdata[d]);
      end
      checks++;
      if ({ready[d], err[d], busy[d]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags%0d: got %b want 000", d, {ready[d], err[d], busy[d]});
      end
      checks++;
      if (leds_o[d] !== 8'h0) begin
        errors++;
        $display("FAIL reset_leds%0d: got %h want 0", d, leds_o[d]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] g;
    int a;
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 1, 0, "wr_10", g, a);
    txn(0, 1, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, "rd_10", g, a);
    txn(0, 0, 1, 32'h14, 32'h0BADF00D, 0, 1, 0, "wr_14", g, a);
    txn(0, 1, 0, 32'h17, 0, 0, 1, 32'h0BADF00D, "rd_17_lowbits", g, a);
    txn(0, 1, 0, 32'h10, 0, 0, 1, 32'hDEADBEEF, "rd_10_again", g, a);
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    int a;
    exp_t e;
    int k;
    bit seen;
    txn(1, 0, 1, 32'h0, 32'hCAFE0000, 0, 1, 0, "b2b_wr0", g, a);
    txn(1, 0, 1, 32'h4, 32'hCAFE0004, 0, 1, 0, "b2b_wr4", g, a);
    @(negedge clk);
    rd_i[1] = 1'b1;
    addr_i[1] = 32'h0;
    e.d = 1; e.err = 0; e.chk = 1; e.data = 32'hCAFE0000; e.nm = "b2b_rd0";
    sb.push_back(e);
    e.data = 32'hCAFE0004; e.nm = "b2b_rd4";
    sb.push_back(e);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (ready[1] === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen || k != 1 || rdata[1] !== e.data) begin
      errors++;
      $display("FAIL %s: got seen=%b lat=%0d data=%h want 1 1 %h", e.nm, seen, k, rdata[1], e.data);
    end
    addr_i[1] = 32'h4;
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b0 || ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b ready=%b want 0 0", busy[1], ready[1]);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (ready[1] !== 1'b1 || rdata[1] !== e.data || err[1] !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%b data=%h err=%b want 1 %h 0", e.nm, ready[1], rdata[1], err[1], e.data);
    end
    last_rd[1] = 32'hCAFE0004;
    rd_i[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_range();
    logic [31:0] g;
    int a;
    txn(0, 0, 1, 32'h3FC, 32'h00000011, 0, 1, 0, "wr_last", g, a);
    txn(0, 1, 0, 32'h3FC, 0, 0, 1, 32'h00000011, "rd_last", g, a);
    txn(0, 1, 0, 32'h400, 0, 1, 1, 0, "rd_oor", g, a);
    txn(0, 0, 1, 32'h400, 32'hFFFFFFFF, 1, 1, 0, "wr_oor", g, a);
    txn(0, 1, 0, 32'h0, 0, 0, 1, 32'h0, "rd_0_wrapchk", g, a);
    txn(0, 1, 0, 32'h3FC, 0, 0, 1, 32'h00000011, "rd_last_after", g, a);
  endtask

  task automatic test_priority();
    logic [31:0] g;
    int a;
    txn(0, 0, 1, 32'h8, 32'h0, 0, 1, 0, "pri_clear", g, a);
    txn(0, 1, 1, 32'h8, 32'h12345678, 0, 1, 0, "pri_both", g, a);
    txn(0, 1, 0, 32'h8, 0, 0, 1, 32'h12345678, "pri_rd", g, a);
  endtask

  task automatic test_reset_mid();
    logic [31:0] g;
    int a;
    bit saw;
    txn(0, 0, 1, 32'h20, 32'h00000001, 0, 1, 0, "pre_20", g, a);
    @(negedge clk);
    wr_i[0] = 1'b1;
    addr_i[0] = 32'h20;
    wd_i[0] = 32'hAAAA5555;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b want 1", busy[0]);
    end
    reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_i[0] = 1'b0;
      if (ready[0] === 1'b1) saw = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ready_seen=%b busy=%b want 0 0", saw, busy[0]);
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    txn(0, 1, 0, 32'h20, 0, 0, 1, 32'h00000001, "rd_20_after_rst", g, a);
  endtask

  task automatic test_mmio();
    logic [31:0] g1;
    logic [31:0] g2;
    int a1;
    int a2;
`ifdef MEM_MMIO_EN
    txn(0, 0, 1, 32'h4000_0000, 32'h123456A5, 0, 1, 0, "led_wr", g1, a1);
    checks++;
    if (leds_o[0] !== 8'hA5) begin
      errors++;
      $display("FAIL led_val: got %h want a5", leds_o[0]);
    end
    txn(0, 1, 0, 32'h4000_0000, 0, 0, 1, 32'h000000A5, "led_rd", g1, a1);
    txn(0, 1, 0, 32'h4000_0004, 0, 0, 0, 0, "cyc_rd1", g1, a1);
    repeat (5) @(negedge clk);
    txn(0, 1, 0, 32'h4000_0004, 0, 0, 0, 0, "cyc_rd2", g2, a2);
    checks++;
    if (g2 - g1 !== 32'(a2 - a1)) begin
      errors++;
      $display("FAIL cyc_delta: got %0d want %0d", g2 - g1, a2 - a1);
    end
    txn(0, 0, 1, 32'h4000_0004, 32'h5, 0, 1, 0, "cyc_wr", g1, a1);
`else
    txn(0, 0, 1, 32'h4000_0000, 32'h000000A5, 1, 1, 0, "led_wr_off", g1, a1);
    checks++;
    if (leds_o[0] !== 8'h00) begin
      errors++;
      $display("FAIL led_off: got %h want 00", leds_o[0]);
    end
    txn(0, 1, 0, 32'h4000_0004, 0, 1, 1, 0, "cyc_rd_off", g2, a2);
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_range();
    test_priority();
    test_reset_mid();
    test_mmio();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's MemRead/MemWrite/Address/WriteData request interface.
- Holds word-addressed RAM, inserts a programmable number of wait states, and returns ReadData with a one-cycle MemReady pulse.
- The controller holds its request until MemReady.
- Sits between the CPU datapath's IorD address mux and its memory data register.

Parameters:
- DEPTH_WORDS, 256: RAM depth in 32-bit words; must be a power of two.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low.
- MemRead  in  1  read request level, held until MemReady.
- MemWrite  in  1  write request level, held until MemReady.
- Address  in  32  byte address; bits [1:0] ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data; valid in the MemReady cycle, held afterwards.
- MemReady  out  1  one-cycle response pulse.
- MemError  out  1  one-cycle pulse, coincident with MemReady, on an out-of-range access.
- Busy  out  1  high from acceptance until the response cycle, inclusive.
- leds  out  8  MMIO LED register; tied 0 when MMIO is disabled.

Behaviour:
- Reset: when reset==0 at a clk edge:
  - ReadData=0, MemReady=0, MemError=0, Busy=0, leds=0, wait counter=0, cycle counter=0, state=IDLE.
  - Applies even mid-transaction: a pending write is discarded and no MemReady is issued.
  - RAM contents are not reset.
- IDLE:
  - If MemWrite or MemRead is 1, latch op, Address and WriteData.
  - Write has priority when both are high.
  - Busy<=1. Go to WAIT if LATENCY>0, otherwise to RESP.
- WAIT: count LATENCY cycles, then go to RESP. Input changes are ignored, since the request is already latched.
- RESP:
  - MemReady=1 for exactly one cycle.
  - Read: ReadData <= RAM[index], updated at the edge entering RESP so it is visible during RESP.
  - Write: RAM[index] <= latched WriteData at the end of RESP.
  - Leave RESP to IDLE; Busy=0 in IDLE.
- Total latency: acceptance edge to MemReady is LATENCY+1 cycles. At least one IDLE cycle separates back-to-back transactions.
- Index: (Address - BASE_ADDR)>>2.
- Out of range (index >= DEPTH_WORDS, or Address < BASE_ADDR):
  - Read returns 0; write is dropped.
  - MemError pulses with MemReady.
- Request deasserted in IDLE: stay IDLE, no response.
- ReadData keeps its last value across writes and idle cycles.
- Same-address write then read returns the new data, because the write commits before the next acceptance.

Optional Feature:
- Macro: MEM_MMIO_EN.
- Defined:
  - Address 32'h4000_0000: read/write LED register. Writes latch WriteData[7:0] into leds; reads return {24'b0, leds}.
  - Address 32'h4000_0004: read-only free-running 32-bit cycle counter. Increments every clk, wraps at 2^32-1→0, resets to 0. Writes are ignored with no MemError.
  - MMIO accesses use the same LATENCY and handshake as RAM accesses.
- Not defined: these addresses are ordinary out-of-range addresses (MemError), and leds stays 0.

Test Plan:
1. LATENCY=2: write 0xDEADBEEF to 0x10, hold until MemReady, then read 0x10 -> MemReady exactly 3 cycles after each acceptance, ReadData=0xDEADBEEF, MemError=0.
2. LATENCY=0: back-to-back reads of 0x0 and 0x4 with the request held continuously -> MemReady pulses 2 cycles apart, Busy low for one cycle between them.
3. Read 0x400 with DEPTH_WORDS=256 -> ReadData=0, MemError=1 with MemReady. A write to 0x400 leaves prior RAM contents unchanged.
4. MemRead=MemWrite=1, Address=0x8, WriteData=0x12345678, then a plain read of 0x8 -> returns 0x12345678.
5. Write 0xAAAA5555 to 0x20 and drop reset to 0 during WAIT -> no MemReady; the next read of 0x20 does not return 0xAAAA5555 (the address was pre-written with 0x1).
6. With MEM_MMIO_EN: write 0xA5 to 0x4000_0000 -> leds=0xA5, readback 0x000000A5. Two reads of 0x4000_0004 spaced N cycles apart differ by N. Without MEM_MMIO_EN the same write -> MemError=1, leds=0.
